// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, Nk/Nr lookups, S-box and xtime.
package aes_pkg;

  localparam logic [1:0] KLEN_128  = 2'd0;
  localparam logic [1:0] KLEN_192  = 2'd1;
  localparam logic [1:0] KLEN_256  = 2'd2;
  localparam logic [1:0] KLEN_RSVD = 2'd3;

  // Word-address width; covers the largest schedule (60 words).
  localparam int WIDX = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } ks_state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] klen);
    case (klen)
      KLEN_128: return 4'd4;
      KLEN_192: return 4'd6;
      KLEN_256: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] klen);
    case (klen)
      KLEN_128: return 4'd10;
      KLEN_192: return 4'd12;
      KLEN_256: return 4'd14;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup for a single byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = sbox(byte_i);

endmodule

// File: rtl/key_schedule_seq.sv
// AES key expansion engine: builds the full word schedule one word per clock
// and serves registered 128-bit round keys from the stored schedule.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [32*MAX_NK-1:0] key,
  input  logic [3:0]           rk_idx,
  output logic [127:0]         rk,
  output logic                 busy,
  output logic                 done,
  output logic                 key_ready,
  output logic                 err
);

  localparam int NW = 4 * (MAX_NK + 7);
  localparam int KW = 32 * MAX_NK;

  ks_state_e         state_q, state_d;
  logic [WIDX-1:0]   i_q, i_d;
  logic [2:0]        pos_q, pos_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [3:0]        nk_q, nk_d;
  logic [3:0]        nr_q, nr_d;
  logic              key_ready_q, key_ready_d;
  logic              err_q, err_d;
  logic [127:0]      rk_q, rk_d;
  logic [31:0]       w_q [NW];
  logic [31:0]       w_d [NW];

  logic [3:0]        nk_in;
  logic              legal, accept, reject, last_write;
  logic [31:0]       prev_word, far_word, rot_word, sub_in, sub_out, temp_word, new_word;

  // Lengths wider than the configured storage are rejected like the reserved code.
  assign nk_in      = nk_of(key_len);
  assign legal      = (key_len != KLEN_RSVD) && (nk_in <= 4'(MAX_NK));
  assign accept     = (state_q == S_IDLE) && start && legal;
  assign reject     = (state_q == S_IDLE) && start && !legal;
  assign last_write = (state_q == S_EXPAND) && (i_q == {nr_q, 2'b11});

  assign prev_word = w_q[i_q - WIDX'(1)];
  assign far_word  = w_q[i_q - {2'b00, nk_q}];
  assign rot_word  = {prev_word[23:0], prev_word[31:24]};
  assign sub_in    = (pos_q == 3'd0) ? rot_word : prev_word;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (sub_in[8*g +: 8]),
      .byte_o (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp_word = prev_word;
    if (pos_q == 3'd0)
      temp_word = sub_out ^ {rcon_q, 24'h0};
    else if ((nk_q == 4'd8) && (pos_q == 3'd4))
      temp_word = sub_out;
    new_word = far_word ^ temp_word;
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    pos_d       = pos_q;
    rcon_d      = rcon_q;
    nk_d        = nk_q;
    nr_d        = nr_q;
    key_ready_d = key_ready_q;
    err_d       = reject;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_EXPAND;
          i_d         = {2'b00, nk_in};
          pos_d       = 3'd0;
          rcon_d      = 8'h01;
          nk_d        = nk_in;
          nr_d        = nr_of(key_len);
          key_ready_d = 1'b0;
        end
      end
      S_EXPAND: begin
        i_d   = i_q + WIDX'(1);
        pos_d = ({1'b0, pos_q} == (nk_q - 4'd1)) ? 3'd0 : pos_q + 3'd1;
        if (pos_q == 3'd0)
          rcon_d = xtime(rcon_q);
        if (last_write) begin
          state_d     = S_DONE;
          key_ready_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The key words all land on the accepting edge; expansion then adds one word per edge.
  always_comb begin
    w_d = w_q;
    if (accept) begin
      for (int j = 0; j < MAX_NK; j++)
        if (4'(j) < nk_in)
          w_d[WIDX'(j)] = key[KW-1-32*j -: 32];
    end else if (state_q == S_EXPAND) begin
      w_d[i_q] = new_word;
    end
  end

  always_comb begin
    rk_d = '0;
    if (key_ready_q && (rk_idx <= nr_q))
      for (int j = 0; j < 4; j++)
        rk_d[127-32*j -: 32] = w_q[{rk_idx, 2'(j)}];
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      pos_q       <= '0;
      rcon_q      <= 8'h01;
      nk_q        <= '0;
      nr_q        <= '0;
      key_ready_q <= 1'b0;
      err_q       <= 1'b0;
      rk_q        <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      pos_q       <= pos_d;
      rcon_q      <= rcon_d;
      nk_q        <= nk_d;
      nr_q        <= nr_d;
      key_ready_q <= key_ready_d;
      err_q       <= err_d;
      rk_q        <= rk_d;
    end
  end

  assign busy      = (state_q == S_EXPAND);
  assign done      = (state_q == S_DONE);
  assign key_ready = key_ready_q;
  assign err       = err_q;
  assign rk        = rk_q;

endmodule
